// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the iterative right shifter: default sizes,
// shift-mode codes and the controller state encoding.
package shift_right_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-position right shift; the mirror of the left shifter.
// Only the incoming msb depends on the mode; code 11 falls through to logical.
module shift_right_step
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_value
);

  logic w_msb;

  always_comb begin
    w_msb = 1'b0;
    case (i_mode)
      MODE_ASR: w_msb = i_value[WIDTH-1];
      MODE_ROR: w_msb = i_value[0];
      default:  w_msb = 1'b0;
    endcase
  end

  assign o_value = {w_msb, i_value[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit position per clock under a latched mode,
// with a counter, a result register and a one-cycle done pulse.
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input_value,
  input  logic [CNT_W-1:0] shift_amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted_value,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request sampled on the rising edge and accepted
  // only in IDLE or DONE (busy=0); while busy=1 it is ignored entirely.
  // done is a one-cycle registered pulse qualifying shifted_value, which
  // then holds until the next accepted start.

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_step_value;
  logic             w_accept;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_value (r_value),
    .i_mode  (r_mode),
    .o_value (w_step_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = (shift_amt != '0) ? SHIFT : DONE;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_LSR;
    end else if (w_accept) begin
      r_value <= input_value;
      r_cnt   <= shift_amt;
      r_mode  <= mode;
    end else if (r_state == SHIFT) begin
      r_value <= w_step_value;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign busy          = (r_state == SHIFT);
  assign done          = (r_state == DONE);
  assign shifted_value = r_value;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed and random stimulus for shift_right_seq with an expected-result
// queue popped on every done pulse.
module tb_shift_right_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] input_value;
  logic [3:0]  shift_amt;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] shifted_value;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          n_vec;
  int          n_err;

  shift_right_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .input_value   (input_value),
    .shift_amt     (shift_amt),
    .mode          (mode),
    .busy          (busy),
    .done          (done),
    .shifted_value (shifted_value),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] v, input int amt, input logic [1:0] md);
    logic [31:0] dbl;
    logic [15:0] res;
    dbl = {v, v} >> amt;
    case (md)
      2'b01:   res = 16'($signed(v) >>> amt);
      2'b10:   res = dbl[15:0];
      default: res = v >> amt;
    endcase
    return res;
  endfunction

  // driver: one-cycle start pulse; result expectation queued at drive time
  task automatic start_op(input logic [15:0] v, input logic [3:0] amt, input logic [1:0] md,
                          input logic [15:0] exp, input bit push);
    input_value = v;
    shift_amt   = amt;
    mode        = md;
    start       = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // called just after the accepting edge; counts edges until done appears
  task automatic wait_done(input int exp_lat, input bit inject, input string tag);
    int lat    = 0;
    int busy_n = 0;
    bit seen   = 0;
    logic [15:0] exp;
    while (!seen && lat <= 40) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_n++;
        if (inject && lat == 2) begin
          start = 1'b1; input_value = 16'hFFFF; shift_amt = 4'd1; mode = 2'b01;
        end else if (inject && lat == 3) begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, 32'(shifted_value), 32'(exp));
    end
  endtask

  // done must drop after one cycle and the result must hold
  task automatic check_hold(input logic [15:0] exp, input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(shifted_value), 32'(exp));
  endtask

  initial begin
    int n_done;
    logic [15:0] rv;
    logic [3:0]  ra;
    logic [1:0]  rm;
    logic [15:0] re;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    input_value = '0;
    shift_amt = '0;
    mode = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_value", 32'(shifted_value), 32'h0000);
    check("rst_state", 32'(dbg_state), 32'd0);
    n_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("idle_no_done", 32'(n_done), 32'd0);

    start_op(16'h8001, 4'd1, 2'b00, 16'h4000, 1);
    wait_done(1, 0, "lsr1");
    check_hold(16'h4000, "lsr1");

    start_op(16'h8000, 4'd15, 2'b01, 16'hFFFF, 1);
    wait_done(15, 0, "asr15_neg");
    check_hold(16'hFFFF, "asr15_neg");

    start_op(16'h7FFF, 4'd15, 2'b01, 16'h0000, 1);
    wait_done(15, 0, "asr15_pos");

    start_op(16'h0001, 4'd4, 2'b10, 16'h1000, 1);
    wait_done(4, 0, "ror4");

    start_op(16'hF00F, 4'd4, 2'b11, 16'h0F00, 1);
    wait_done(4, 0, "mode11");
    check_hold(16'h0F00, "mode11");

    // zero shift, then a new start held through its DONE cycle
    input_value = 16'h1234; shift_amt = 4'd0; mode = 2'b00; start = 1'b1;
    exp_q.push_back(16'h1234);
    @(posedge clk); #1;
    input_value = 16'hFFFF; shift_amt = 4'd2; mode = 2'b00;
    wait_done(0, 0, "zero_shift");
    exp_q.push_back(16'h3FFF);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, 0, "b2b");
    check_hold(16'h3FFF, "b2b");

    // start pulsed mid-shift must be ignored
    start_op(16'h00F0, 4'd6, 2'b10, 16'hC003, 1);
    wait_done(6, 1, "busy_ignore");
    check_hold(16'hC003, "busy_ignore");

    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(0, 16'hFFFF));
      ra = 4'($urandom_range(0, 15));
      rm = 2'($urandom_range(0, 3));
      re = model(rv, int'(ra), rm);
      start_op(rv, ra, rm, re, 1);
      wait_done(int'(ra), 0, "rand");
    end

    // asynchronous reset in the middle of a shift
    start_op(16'hABCD, 4'd8, 2'b00, 16'h0000, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_value", 32'(shifted_value), 32'h0000);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("midrst_quiet", 32'(n_done), 32'd0);
    check("midrst_idle", 32'(dbg_state), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
